vga_obj_move_ctrl: RTL
======================

Name: vga_obj_move_ctrl

Overview:
- Frame-synchronised position controller for the square overlay object drawn by the 640x480 VGA pixel generator.
- Accepts move requests from a button/keypad front end over a req/ack handshake and holds one pending move.
- Applies the pending move only at the start of vertical blanking, so the object never tears mid-frame.
- Clamps the object inside the active window and drives obj_x/obj_y (object centre, in raw hc/vc counter coordinates) to the pixel generator.

Parameters:
HBP, 144, first active hc value
HFP, 784, first hc value after active video
VBP, 31, first active vc value
VFP, 511, first vc value after active video (vblank start line)
HALF, 20, object half-size in pixels
STEP, 4, pixels moved per accepted request

Ports:
dclk  in  1  pixel clock, 25 MHz
clr  in  1  asynchronous reset, active-high
hc  in  10  horizontal counter from timing generator
vc  in  10  vertical counter from timing generator
mv_req  in  1  move request, level, held until mv_ack
mv_dir  in  2  direction: 00 up, 01 down, 10 left, 11 right; stable while mv_req high
mv_ack  out  1  one-cycle acceptance pulse
obj_x  out  10  object centre hc coordinate
obj_y  out  10  object centre vc coordinate
upd_done  out  1  one-cycle pulse, coincident with new obj_x/obj_y
busy  out  1  high whenever state != IDLE
frame_cnt  out  8  vblank-start counter, wraps 255->0

Behaviour:
- Reset is taken from clr, asynchronous, active-high; clock is dclk. All state is updated on the rising edge of dclk.
- Reset values:
  - state=IDLE; mv_ack=0; upd_done=0; busy=0; frame_cnt=0.
  - obj_x=(HBP+HFP)/2=464; obj_y=(VBP+VFP)/2=271.
  - Pending slot is empty.
- Limits:
  - XMIN=HBP+HALF=164; XMAX=HFP-1-HALF=763.
  - YMIN=VBP+HALF=51; YMAX=VFP-1-HALF=490.
- vblank_start is combinational: (vc==VFP && hc==0). It is true for exactly one dclk cycle per frame.
- frame_cnt increments on every edge where vblank_start is true, in every state.
- FSM states: IDLE, ARMED, CALC, COMMIT.
  - IDLE: if mv_req=1 at an edge, latch mv_dir into the slot, set mv_ack=1 for the following cycle, and go to ARMED. Otherwise stay in IDLE.
  - ARMED: mv_req is ignored and no ack is issued. If vblank_start is true at an edge, go to CALC; otherwise stay in ARMED.
  - CALC: compute the candidate position using an 11-bit intermediate, then clamp.
    - up: y-STEP, floor at YMIN.
    - down: y+STEP, ceiling at YMAX.
    - left: x-STEP, floor at XMIN.
    - right: x+STEP, ceiling at XMAX.
    - The other axis is unchanged. Go to COMMIT.
  - COMMIT: write the candidate to obj_x/obj_y, set upd_done=1 for one cycle, clear the slot, go to IDLE.
- Latency: vblank_start is sampled at edge E0; the new obj_x/obj_y and upd_done are visible after edge E2. The update therefore lands during vblank line VFP, far from active video.
- Handshake:
  - mv_ack is high for exactly one cycle per accepted request.
  - The requester must drop mv_req in the cycle mv_ack is seen.
  - If mv_req is still high when the FSM returns to IDLE, it is treated as a new request.
  - At most one move is applied per frame.
- Boundary cases:
  - Object already at a limit: the position is unchanged, but upd_done still pulses.
  - Request in the same cycle as COMMIT: not accepted; it is accepted at the first IDLE edge that follows.
  - Request accepted while vblank_start is already true that same cycle: the FSM is not yet ARMED, so the move waits for the next frame.
  - clr mid-operation (any state): immediate return to reset values; the pending move is discarded; no ack or done pulse is produced.
- No combinational path from mv_req to mv_ack; all outputs are registered.

Test Plan:
1. Reset, then run 2 frames with no requests -> obj_x=464, obj_y=271, mv_ack/upd_done never high, frame_cnt=2.
2. mv_req=1, mv_dir=11 at mid-frame -> one mv_ack pulse, busy=1; obj_x stays 464 until vc=511/hc=0, then 2 cycles later obj_x=468 with upd_done pulse; obj_y=271.
3. Issue 200 "left" requests, one per frame -> obj_x decreases by 4 per frame and then saturates at 164; final frames still pulse upd_done with obj_x=164.
4. Second request asserted while ARMED -> no ack until the cycle after COMMIT; its move lands in the following frame (two frames total, y 271->267->263 for two "up" requests).
5. Assert clr during CALC of a "down" move -> obj_y=271, busy=0, frame_cnt=0, no upd_done; the next request behaves normally.
6. Run 256 frames -> frame_cnt wraps 255->0 exactly at vblank_start.

Source files
------------

// File: rtl/vga_obj_move_ctrl_if.sv
// rtl/vga_obj_move_ctrl_if.sv - move request handshake between button front end and position controller
//
// Purpose: carries one move request (level req, held until ack) and the
// one-cycle acceptance pulse back to the requester.
// Signals:
//   mv_req  requester -> controller  move request, held until mv_ack
//   mv_dir  requester -> controller  00 up, 01 down, 10 left, 11 right
//   mv_ack  controller -> requester  one-cycle acceptance pulse
interface vga_obj_move_ctrl_if;
  logic       mv_req;
  logic [1:0] mv_dir;
  logic       mv_ack;

  modport master (output mv_req, output mv_dir, input mv_ack);
  modport slave  (input mv_req, input mv_dir, output mv_ack);
endinterface

// File: rtl/vga_obj_move_ctrl.sv
// rtl/vga_obj_move_ctrl.sv - frame-synchronised position controller for the VGA overlay square
//
// Purpose: accepts one pending move over the mv handshake, applies it at the
// start of vertical blanking, clamps the object centre inside the active
// window and presents obj_x/obj_y to the pixel generator.
// Ports:
//   dclk       pixel clock
//   clr        asynchronous reset, active-high
//   hc, vc     horizontal / vertical counters from the timing generator
//   mv         move request handshake (slave side)
//   obj_x/y    object centre in raw hc/vc coordinates
//   upd_done   one-cycle pulse coincident with new obj_x/obj_y
//   busy       high whenever a move is pending or being applied
//   frame_cnt  count of vblank starts, wraps 255->0
module vga_obj_move_ctrl #(
  parameter int HBP  = 144,
  parameter int HFP  = 784,
  parameter int VBP  = 31,
  parameter int VFP  = 511,
  parameter int HALF = 20,
  parameter int STEP = 4
) (
  input  logic                 dclk,
  input  logic                 clr,
  input  logic [9:0]           hc,
  input  logic [9:0]           vc,
  vga_obj_move_ctrl_if.slave   mv,
  output logic [9:0]           obj_x,
  output logic [9:0]           obj_y,
  output logic                 upd_done,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam logic [10:0] XMIN  = 11'(HBP + HALF);
  localparam logic [10:0] XMAX  = 11'(HFP - 1 - HALF);
  localparam logic [10:0] YMIN  = 11'(VBP + HALF);
  localparam logic [10:0] YMAX  = 11'(VFP - 1 - HALF);
  localparam logic [10:0] STP   = 11'(STEP);
  localparam logic [9:0]  X_RST = 10'((HBP + HFP) / 2);
  localparam logic [9:0]  Y_RST = 10'((VBP + VFP) / 2);

  typedef enum logic [1:0] {IDLE, ARMED, CALC, COMMIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] slot_dir;
  logic [9:0] cand_x, cand_y;
  logic [9:0] calc_x, calc_y;
  logic [10:0] x_dn, x_up, y_dn, y_up;
  logic       ack_nxt, done_nxt;
  logic       vblank_start;

  assign vblank_start = (vc == 10'(VFP)) && (hc == 10'd0);
  assign busy         = (state != IDLE);

  // Candidate position from the pending direction; 11-bit intermediates so
  // an underflow shows up in bit 10 and is caught by the floor test.
  always_comb begin
    x_dn   = {1'b0, obj_x} - STP;
    x_up   = {1'b0, obj_x} + STP;
    y_dn   = {1'b0, obj_y} - STP;
    y_up   = {1'b0, obj_y} + STP;
    calc_x = obj_x;
    calc_y = obj_y;
    case (slot_dir)
      2'b00:   calc_y = (y_dn[10] || y_dn < YMIN) ? YMIN[9:0] : y_dn[9:0];
      2'b01:   calc_y = (y_up > YMAX) ? YMAX[9:0] : y_up[9:0];
      2'b10:   calc_x = (x_dn[10] || x_dn < XMIN) ? XMIN[9:0] : x_dn[9:0];
      default: calc_x = (x_up > XMAX) ? XMAX[9:0] : x_up[9:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (mv.mv_req) begin
          state_nxt = ARMED;
          ack_nxt   = 1'b1;
        end
      end
      ARMED:   if (vblank_start) state_nxt = CALC;
      CALC:    state_nxt = COMMIT;
      COMMIT: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      mv.mv_ack <= 1'b0;
      upd_done  <= 1'b0;
      frame_cnt <= 8'd0;
      obj_x     <= X_RST;
      obj_y     <= Y_RST;
      cand_x    <= X_RST;
      cand_y    <= Y_RST;
      slot_dir  <= 2'b00;
    end else begin
      state     <= state_nxt;
      mv.mv_ack <= ack_nxt;
      upd_done  <= done_nxt;
      if (vblank_start) frame_cnt <= frame_cnt + 8'd1;
      if (state == IDLE && mv.mv_req) slot_dir <= mv.mv_dir;
      if (state == CALC) begin
        cand_x <= calc_x;
        cand_y <= calc_y;
      end
      if (state == COMMIT) begin
        obj_x    <= cand_x;
        obj_y    <= cand_y;
        slot_dir <= 2'b00;
      end
    end
  end

endmodule
